bram_read_arbiter: RTL and testbench

Shares the single read-only parameter BRAM (8-bit words, 2-cycle read latency) among NUM_REQ loader blocks (weight/bias loaders per layer). Each requester asks for a burst (base address, length). The arbiter grants one burst at a time and drives the BRAM address/enable pins. It returns the read data as a valid-qualified stream to the granted requester and pulses a per-requester done. It sits between the loaders and the one BRAM instance, so no loader instantiates its own BRAM.

---
 rtl/bram_read_arbiter.sv | 159 +++++++++++++++
 tb/tb_bram_read_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares one read-only parameter BRAM among NUM_REQ burst loaders
//   clk, rst          clock, asynchronous active-high reset
//   req/req_addr/len  per-requester burst request, base address and length (slice i)
//   grant             one-hot owner of the current burst
//   rd_valid/data/last read stream to the owner, rd_last on the final word
//   burst_done        one-cycle pulse to the owner when its burst ends
//   busy              arbiter not idle
//   bram_en/ren/addr  BRAM control, bram_dout BRAM read data (RD_LAT cycles late)
//   Build option: define BRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins)
//   instead of round-robin.
module bram_read_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int W          = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 15,
  parameter int RD_LAT     = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]  req_len,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          rd_valid,
  output logic [W-1:0]                  rd_data,
  output logic                          rd_last,
  output logic [NUM_REQ-1:0]            burst_done,
  output logic                          busy,
  output logic                          bram_en,
  output logic                          bram_ren,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  input  logic [W-1:0]                  bram_dout
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [IW-1:0]         owner_q, owner_d, win, owner_inc;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, win_addr;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d, win_len;
  logic                  en_q, en_d, ren_q, ren_d;
  logic [RD_LAT-1:0]     vpipe_q, vpipe_d, lpipe_q, lpipe_d;
  logic [W-1:0]          data_q, data_d;

  assign owner_inc = owner_q == IW'(NUM_REQ - 1) ? '0 : owner_q + IW'(1);

`ifdef BRAM_ARB_FIXED_PRIO_EN
  // descending scan so the lowest set index is the last one written
  always_comb begin
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (req[IW'(k)]) win = IW'(k);
  end
`else
  logic [IW-1:0] rr_q, rr_d;
  // descending scan of offsets from the pointer: the smallest offset wins
  always_comb begin
    int j;
    win = '0;
    j = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(rr_q) + k;
      j = j >= NUM_REQ ? j - NUM_REQ : j;
      if (req[IW'(j)]) win = IW'(j);
    end
  end
  always_comb rr_d = state_q == S_DONE ? owner_inc : rr_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_q <= '0;
    else rr_q <= rr_d;
`endif

  assign win_addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
  assign win_len  = req_len[win*LEN_WIDTH +: LEN_WIDTH];

  // valid/last shift registers track issued reads through the BRAM latency
  assign vpipe_d = RD_LAT'({vpipe_q, ren_q});
  assign lpipe_d = RD_LAT'({lpipe_q, ren_q && cnt_q == '0});
  assign data_d  = rd_valid ? bram_dout : data_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    ren_d   = ren_q;
    case (state_q)
      S_IDLE: if (|req) begin
        grant_d = NUM_REQ'(1) << win;
        owner_d = win;
        if (win_len == '0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ISSUE;
          addr_d  = win_addr;
          cnt_d   = win_len - LEN_WIDTH'(1);
          en_d    = 1'b1;
          ren_d   = 1'b1;
        end
      end
      S_ISSUE: if (cnt_q == '0) begin
        state_d = S_DRAIN;
        ren_d   = 1'b0;
      end else begin
        addr_d = addr_q + ADDR_WIDTH'(1);
        cnt_d  = cnt_q - LEN_WIDTH'(1);
      end
      S_DRAIN: if (vpipe_d == '0) begin
        state_d = S_DONE;
        en_d    = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      owner_q <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ren_q   <= 1'b0;
      vpipe_q <= '0;
      lpipe_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      ren_q   <= ren_d;
      vpipe_q <= vpipe_d;
      lpipe_q <= lpipe_d;
      data_q  <= data_d;
    end

  assign grant      = grant_q;
  assign rd_valid   = vpipe_q[RD_LAT-1];
  assign rd_last    = vpipe_q[RD_LAT-1] & lpipe_q[RD_LAT-1];
  assign rd_data    = rd_valid ? bram_dout : data_q;
  assign burst_done = state_q == S_DONE ? grant_q : '0;
  assign busy       = state_q != S_IDLE;
  assign bram_en    = en_q;
  assign bram_ren   = ren_q;
  assign bram_addr  = addr_q;
endmodule

// File: tb/tb_bram_read_arbiter.sv
// tb_bram_read_arbiter: directed table, corner sequences and random traffic against a timeline model
module tb_bram_read_arbiter;
  localparam int N = 4, AW = 15, LW = 15, RL = 2;
  logic clk = 1'b0, rst;
  logic [N-1:0] req;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N-1:0] grant, burst_done;
  logic rd_valid, rd_last, busy, bram_en, bram_ren;
  logic [7:0] rd_data, bram_dout, s1;
  logic [AW-1:0] bram_addr;
  int n_vec = 0, n_bad = 0;

  bram_read_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_len(req_len),
    .grant(grant), .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
    .burst_done(burst_done), .busy(busy), .bram_en(bram_en), .bram_ren(bram_ren),
    .bram_addr(bram_addr), .bram_dout(bram_dout)
  );

  always #5 clk = ~clk;

  // BRAM holding word = addr[7:0], two-cycle read latency
  always @(posedge clk) begin
    s1 <= bram_addr[7:0];
    bram_dout <= s1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // timeline model: after a grant becomes visible (offset 0) the burst is a fixed schedule
  int m_act, m_off, m_own, m_len, m_base, m_rr, e_end, eg, w;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_grant", grant, 0); chk("rst_busy", busy, 0); chk("rst_valid", rd_valid, 0);
      chk("rst_en", bram_en, 0); chk("rst_ren", bram_ren, 0); chk("rst_done", burst_done, 0);
      chk("rst_addr", bram_addr, 0); chk("rst_data", rd_data, 0);
      m_act = 0; m_rr = 0;
    end else begin
      if (m_act != 0) m_off++;
      e_end = m_len == 0 ? 0 : m_len + RL;
      eg = m_act != 0 ? (1 << m_own) : 0;
      chk("grant", grant, eg);
      chk("busy", busy, m_act);
      chk("burst_done", burst_done, (m_act != 0 && m_off == e_end) ? eg : 0);
      chk("bram_ren", bram_ren, int'(m_act != 0 && m_off < m_len));
      chk("bram_en", bram_en, int'(m_act != 0 && m_len > 0 && m_off < m_len + RL));
      if (m_act != 0 && m_off < m_len) chk("bram_addr", bram_addr, (m_base + m_off) % 32768);
      chk("rd_valid", rd_valid, int'(m_act != 0 && m_off >= RL && m_off < m_len + RL));
      chk("rd_last", rd_last, int'(m_act != 0 && m_len > 0 && m_off == m_len + RL - 1));
      if (rd_valid) chk("rd_data", rd_data, (m_base + m_off - RL) % 256);
      if (m_act != 0 && m_off == e_end) begin
        m_act = 0;
        m_rr = (m_own + 1) % N;
      end else if (m_act == 0 && req != 0) begin
        w = -1;
`ifdef BRAM_ARB_FIXED_PRIO_EN
        for (int k = N - 1; k >= 0; k--) if (req[k]) w = k;
`else
        for (int k = 0; k < N; k++) if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
`endif
        m_own = w; m_act = 1; m_off = -1;
        m_base = int'(req_addr[w*AW +: AW]);
        m_len = int'(req_len[w*LW +: LW]);
      end
    end
  end

  typedef struct {
    int who, addr, len;
    int e_grant, e_nval, e_nren, e_nlast, e_done, e_faddr, e_laddr, e_ldata;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int g, nval, nren, nlast, done_off, start, faddr, laddr, ldata, nb, nv, prev, gi, sawg, done0, bad3, k;
    int order[5], exp_order[5];
    rst = 1'b1; req = '0; req_addr = '0; req_len = '0;
    tbl[0] = '{1, 17088, 10, 4'b0010, 10, 10, 1, 12, 17088, 17097, 8'hC9};
    tbl[1] = '{2, 500, 0, 4'b0100, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 32767, 3, 4'b0001, 3, 3, 1, 5, 32767, 1, 8'h01};
    tbl[3] = '{3, 16'h1234, 1, 4'b1000, 1, 1, 1, 3, 16'h1234, 16'h1234, 8'h34};
`ifdef BRAM_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 2, 3, 0};
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req[tbl[i].who] = 1'b1;
      req_addr[tbl[i].who*AW +: AW] = AW'(tbl[i].addr);
      req_len[tbl[i].who*LW +: LW] = LW'(tbl[i].len);
      g = 0; nval = 0; nren = 0; nlast = 0; done_off = -1; start = -1; faddr = 0; laddr = 0; ldata = 0;
      for (int c = 0; c < 100 && done_off < 0; c++) begin
        @(negedge clk);
        if (grant != 0 && start < 0) begin start = c; g = int'(grant); end
        if (bram_ren) begin if (nren == 0) faddr = int'(bram_addr); laddr = int'(bram_addr); nren++; end
        if (rd_valid) begin nval++; ldata = int'(rd_data); end
        if (rd_last) nlast++;
        if (burst_done != 0) done_off = c - start;
      end
      @(posedge clk); #1 req[tbl[i].who] = 1'b0;
      chk("tbl_grant", g, tbl[i].e_grant);
      chk("tbl_nvalid", nval, tbl[i].e_nval);
      chk("tbl_nren", nren, tbl[i].e_nren);
      chk("tbl_nlast", nlast, tbl[i].e_nlast);
      chk("tbl_done_offset", done_off, tbl[i].e_done);
      chk("tbl_first_addr", faddr, tbl[i].e_faddr);
      chk("tbl_last_addr", laddr, tbl[i].e_laddr);
      chk("tbl_last_data", ldata, tbl[i].e_ldata);
    end

    // reset in the middle of an address phase
    @(posedge clk); #1;
    req[3] = 1'b1; req_addr[3*AW +: AW] = AW'(1000); req_len[3*LW +: LW] = LW'(10);
    sawg = 0;
    for (int c = 0; c < 20 && sawg == 0; c++) begin @(negedge clk); if (grant != 0) sawg = 1; end
    chk("rstseq_grant_seen", sawg, 1);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1; req[3] = 1'b0;
    req[0] = 1'b1; req_addr[0 +: AW] = AW'(2000); req_len[0 +: LW] = LW'(4);
    @(negedge clk);
    chk("rstseq_grant", grant, 0); chk("rstseq_valid", rd_valid, 0);
    chk("rstseq_en", bram_en, 0); chk("rstseq_done", burst_done, 0);
    @(posedge clk); #1 rst = 1'b0;
    sawg = 0; nv = 0; done0 = 0; bad3 = 0;
    for (int c = 0; c < 50 && done0 == 0; c++) begin
      @(negedge clk);
      if (grant == 4'b0001) sawg = 1;
      if (rd_valid) nv++;
      if (burst_done[3]) bad3++;
      if (burst_done[0]) done0 = 1;
    end
    @(posedge clk); #1 req[0] = 1'b0;
    chk("rstseq_regrant", sawg, 1); chk("rstseq_words", nv, 4);
    chk("rstseq_done0", done0, 1); chk("rstseq_no_done3", bad3, 0);

    // all four requesting, fresh pointer
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int r = 0; r < N; r++) begin
      req_addr[r*AW +: AW] = AW'(r * 100);
      req_len[r*LW +: LW] = LW'(2);
    end
    req = 4'hF;
    order = '{-1, -1, -1, -1, -1};
    nb = 0; nv = 0; prev = 0;
    for (int c = 0; c < 200 && nb < 5; c++) begin
      @(negedge clk);
      if (rd_valid) nv++;
      if (grant != 0 && prev == 0) begin
        gi = -1;
        for (int b = 0; b < N; b++) if (grant[b]) gi = b;
        order[nb] = gi;
      end
      if (burst_done != 0) begin chk("rr_words", nv, 2); nv = 0; nb++; end
      prev = int'(grant);
    end
    @(posedge clk); #1 req = '0;
    for (int i = 0; i < 5; i++) chk("rr_order", order[i], exp_order[i]);

    // drop req and move the address after the grant
    @(posedge clk); #1;
    req[3] = 1'b1; req_addr[3*AW +: AW] = AW'(3000); req_len[3*LW +: LW] = LW'(6);
    sawg = 0;
    for (int c = 0; c < 20 && sawg == 0; c++) begin @(negedge clk); if (grant == 4'b1000) sawg = 1; end
    chk("mid_grant", sawg, 1);
    @(posedge clk); #1;
    req[3] = 1'b0; req_addr[3*AW +: AW] = AW'(5000); req_len[3*LW +: LW] = LW'(9);
    nv = 0; g = 0;
    for (int c = 0; c < 50 && g == 0; c++) begin
      @(negedge clk);
      if (rd_valid) begin chk("mid_data", rd_data, (3000 + nv) % 256); nv++; end
      if (burst_done != 0) g = int'(burst_done);
    end
    chk("mid_words", nv, 6); chk("mid_done", g, 4'b1000);

    // random traffic, occasional resets; the timeline model checks every cycle
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = $urandom_range(0, 399) == 0;
      for (k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) req[k] = ~req[k];
        if ($urandom_range(0, 7) == 0) begin
          req_addr[k*AW +: AW] = AW'($urandom);
          req_len[k*LW +: LW] = LW'($urandom_range(0, 6));
        end
      end
    end
    @(posedge clk); #1 rst = 1'b0; req = '0;
    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
